// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional feature: MC_CTRL_ADDI_EN enables the ADDI_EX/ADDI_WB path.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BEQ     = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; FETCH pcwrite/irwrite are qualified later.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure combinational state -> control-word decoder (Moore part of the outputs).
// Optional feature: MC_CTRL_ADDI_EN decodes the ADDI_EX/ADDI_WB states.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  // Default everything low, then raise only what each state needs.
  always_comb begin
    c = '0;
    case (state_i)
      FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE: c.alusrcb = SRCB_IMM_SH2;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      RWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQ: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      ADDI_WB: c.regwrite = 1'b1;
`endif
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Holds the state register, next-state logic and MemReady/Op qualification.
// Optional feature: MC_CTRL_ADDI_EN adds the ADDI_EX -> ADDI_WB sequence.
module multicycle_main_control
  import mc_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       IllegalOp
);

  state_t            state_q, state_d;
  // Op is only valid in DECODE, so remember lw vs sw for MEMADR.
  logic              is_lw_q, is_lw_d;
  logic              illegal;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;
  logic              en;
  logic              fetch_ok;

  mc_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl_bits)
  );

  assign ctrl = ctrl_bits;

  // Next-state selection; Op consulted in DECODE only.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    illegal = 1'b0;
    case (state_q)
      FETCH:  if (MemReady) state_d = DECODE;
      DECODE: begin
        is_lw_d = (Op == OP_LW);
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = ADDI_EX;
`endif
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = is_lw_q ? MEMRD : MEMWR;
      MEMRD:  if (MemReady) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (MemReady) state_d = FETCH;
      EXEC:   state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      JUMP:   state_d = FETCH;
`ifdef MC_CTRL_ADDI_EN
      ADDI_EX: state_d = ADDI_WB;
      ADDI_WB: state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Every output is held low during reset; FETCH writes wait for MemReady.
  assign en       = ~reset;
  assign fetch_ok = (state_q != FETCH) | MemReady;

  assign PCWrite     = en & ctrl.pcwrite & fetch_ok;
  assign IRWrite     = en & ctrl.irwrite & fetch_ok;
  assign PCWriteCond = en & ctrl.pcwritecond;
  assign IorD        = en & ctrl.iord;
  assign MemRead     = en & ctrl.memread;
  assign MemWrite    = en & ctrl.memwrite;
  assign MemtoReg    = en & ctrl.memtoreg;
  assign RegWrite    = en & ctrl.regwrite;
  assign RegDst      = en & ctrl.regdst;
  assign ALUSrcA     = en & ctrl.alusrca;
  assign ALUSrcB     = {2{en}} & ctrl.alusrcb;
  assign PCSource    = {2{en}} & ctrl.pcsource;
  assign ALUOp       = {2{en}} & ctrl.aluop;
  assign IllegalOp   = en & illegal;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: stimulus pushes the expected
// control word for each cycle, a negedge monitor pops and compares.
module tb_multicycle_main_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource, ALUOp;

  multicycle_main_control dut (
    .clock       (clock),
    .reset       (reset),
    .Op          (Op),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .IllegalOp   (IllegalOp)
  );

  always #5 clock = ~clock;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  //              RegWrite RegDst ALUSrcA ALUSrcB[2] PCSource[2] ALUOp[2] IllegalOp
  logic [16:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

  localparam logic [16:0] E_ZERO   = 17'b0;
  localparam logic [16:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_ILLEG  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [16:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0};
`ifdef MC_CTRL_ADDI_EN
  localparam logic [16:0] E_ADDEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_ADDWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
`endif

  typedef struct {
    logic [16:0] w;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: one expected word per cycle, checked mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.w) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.w);
      end
    end
  end

  // Drive one cycle of inputs just after the edge and queue what it should produce.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [16:0] w, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset    = rst;
    Op       = op;
    MemReady = mr;
    e.w      = w;
    e.name   = nm;
    sb.push_back(e);
  endtask

  initial begin
    reset    = 1'b1;
    Op       = 6'd0;
    MemReady = 1'b0;

    // Reset state: everything low, even though the FSM sits in FETCH.
    cyc(1'b1, 6'd0,  1'b1, E_ZERO,   "reset_a");
    cyc(1'b1, 6'd35, 1'b1, E_ZERO,   "reset_b");

    // lw, no waits: 5 cycles; Op changed after DECODE must not matter.
    cyc(1'b0, 6'h3f, 1'b1, E_FETCH,  "lw_fetch");
    cyc(1'b0, 6'd35, 1'b1, E_DECODE, "lw_decode");
    cyc(1'b0, 6'd0,  1'b1, E_MEMADR, "lw_memadr");
    cyc(1'b0, 6'd0,  1'b1, E_MEMRD,  "lw_memrd");
    cyc(1'b0, 6'd0,  1'b1, E_MEMWB,  "lw_memwb");

    // sw with a fetch wait and three MEMWR wait cycles.
    cyc(1'b0, 6'd0,  1'b0, E_FWAIT,  "sw_fetch_wait");
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "sw_fetch");
    cyc(1'b0, 6'd43, 1'b1, E_DECODE, "sw_decode");
    cyc(1'b0, 6'd35, 1'b1, E_MEMADR, "sw_memadr");
    cyc(1'b0, 6'd0,  1'b0, E_MEMWR,  "sw_memwr_w1");
    cyc(1'b0, 6'd0,  1'b0, E_MEMWR,  "sw_memwr_w2");
    cyc(1'b0, 6'd0,  1'b0, E_MEMWR,  "sw_memwr_w3");
    cyc(1'b0, 6'd0,  1'b1, E_MEMWR,  "sw_memwr_done");

    // R-type.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "r_fetch");
    cyc(1'b0, 6'd0,  1'b1, E_DECODE, "r_decode");
    cyc(1'b0, 6'd0,  1'b1, E_EXEC,   "r_exec");
    cyc(1'b0, 6'd0,  1'b1, E_RWB,    "r_rwb");

    // beq.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "beq_fetch");
    cyc(1'b0, 6'd4,  1'b1, E_DECODE, "beq_decode");
    cyc(1'b0, 6'd0,  1'b1, E_BEQ,    "beq_beq");

    // j.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "j_fetch");
    cyc(1'b0, 6'd2,  1'b1, E_DECODE, "j_decode");
    cyc(1'b0, 6'd0,  1'b1, E_JUMP,   "j_jump");

    // addi: legal only with the feature built in.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "addi_fetch");
`ifdef MC_CTRL_ADDI_EN
    cyc(1'b0, 6'd8,  1'b1, E_DECODE, "addi_decode");
    cyc(1'b0, 6'd0,  1'b1, E_ADDEX,  "addi_ex");
    cyc(1'b0, 6'd0,  1'b1, E_ADDWB,  "addi_wb");
`else
    cyc(1'b0, 6'd8,  1'b1, E_ILLEG,  "addi_illegal");
`endif

    // Another unsupported opcode; must return straight to FETCH.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "ill_fetch");
    cyc(1'b0, 6'h3f, 1'b1, E_ILLEG,  "ill_decode");
    cyc(1'b0, 6'd0,  1'b0, E_FWAIT,  "ill_back_fetch");

    // Reset in the middle of a waiting MEMRD.
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "rm_fetch");
    cyc(1'b0, 6'd35, 1'b1, E_DECODE, "rm_decode");
    cyc(1'b0, 6'd0,  1'b1, E_MEMADR, "rm_memadr");
    cyc(1'b0, 6'd0,  1'b0, E_MEMRD,  "rm_memrd_wait");
    cyc(1'b1, 6'd0,  1'b0, E_ZERO,   "rm_reset_a");
    cyc(1'b1, 6'd0,  1'b1, E_ZERO,   "rm_reset_b");
    cyc(1'b0, 6'd0,  1'b1, E_FETCH,  "rm_post_fetch");
    cyc(1'b0, 6'd0,  1'b1, E_DECODE, "rm_post_decode");
    cyc(1'b0, 6'd0,  1'b1, E_EXEC,   "rm_post_exec");
    cyc(1'b0, 6'd0,  1'b1, E_RWB,    "rm_post_rwb");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
